// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM encoding, access size and byte-enable patterns.
package lsu_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for stores and byte/half extraction plus extension for loads.
import lsu_pkg::*;

module lsu_align (
  input  size_e       op_size,
  input  logic        sgn,
  input  logic [1:0]  off,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_val
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  assign byte_val = rdata[{off, 3'b000} +: 8];
  assign half_val = rdata[{off[1], 4'b0000} +: 16];

  // Halfwords only look at off[1]; words ignore the offset entirely.
  always_comb begin
    be       = BE_WORD;
    wdata    = sdata;
    load_val = rdata;
    case (op_size)
      SZ_BYTE: begin
        be       = BE_BYTE << off;
        wdata    = {4{sdata[7:0]}};
        load_val = {{24{sgn & byte_val[7]}}, byte_val};
      end
      SZ_HALF: begin
        be       = BE_HALF << {off[1], 1'b0};
        wdata    = {2{sdata[15:0]}};
        load_val = {{16{sgn & half_val[15]}}, half_val};
      end
      default: begin
        be       = BE_WORD;
        wdata    = sdata;
        load_val = rdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: effective address, single-outstanding request/ready port, load extension.
// Optional MISALIGN_TRAP_EN traps misaligned half/word accesses instead of issuing them.
import lsu_pkg::*;

module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_lb,
  input  logic        is_lh,
  input  logic        is_lw,
  input  logic        is_lbu,
  input  logic        is_lhu,
  input  logic        is_sb,
  input  logic        is_sh,
  input  logic        is_sw,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [31:0] imm,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        bus_err,
  output logic        misalign,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  logic [1:0]       state;
  logic [31:0]      ea;
  logic [31:0]      ea_next;
  size_e            op_size;
  size_e            dec_size;
  logic             sgn;
  logic             dec_signed;
  logic             dec_load;
  logic             dec_store;
  logic             we;
  logic [31:0]      sdata;
  logic [CNT_W-1:0] cnt;
  logic             err;
  logic             mis;
  logic             trap;
  logic [3:0]       st_be;
  logic [31:0]      st_wdata;
  logic [31:0]      load_val;

  assign ea_next = rs1_val + imm;

  // Decoder flags are nominally one-hot; the if-chain fixes priority if they are not.
  always_comb begin
    dec_size   = SZ_WORD;
    dec_signed = 1'b0;
    dec_load   = 1'b0;
    dec_store  = 1'b0;
    if (is_lw) begin
      dec_load = 1'b1;
    end else if (is_lh) begin
      dec_load = 1'b1; dec_size = SZ_HALF; dec_signed = 1'b1;
    end else if (is_lhu) begin
      dec_load = 1'b1; dec_size = SZ_HALF;
    end else if (is_lb) begin
      dec_load = 1'b1; dec_size = SZ_BYTE; dec_signed = 1'b1;
    end else if (is_lbu) begin
      dec_load = 1'b1; dec_size = SZ_BYTE;
    end else if (is_sw) begin
      dec_store = 1'b1;
    end else if (is_sh) begin
      dec_store = 1'b1; dec_size = SZ_HALF;
    end else if (is_sb) begin
      dec_store = 1'b1; dec_size = SZ_BYTE;
    end
  end

`ifdef MISALIGN_TRAP_EN
  assign trap = (dec_load | dec_store) &&
                (((dec_size == SZ_HALF) && ea_next[0]) ||
                 ((dec_size == SZ_WORD) && (ea_next[1:0] != 2'b00)));
`else
  assign trap = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ea        <= '0;
      op_size   <= SZ_BYTE;
      sgn       <= 1'b0;
      we        <= 1'b0;
      sdata     <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      mis       <= 1'b0;
      load_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            ea      <= ea_next;
            op_size <= dec_size;
            sgn     <= dec_signed;
            we      <= dec_store;
            sdata   <= rs2_val;
            cnt     <= '0;
            err     <= 1'b0;
            mis     <= trap;
            state   <= ((dec_load | dec_store) && !trap) ? S_REQ : S_DONE;
          end
        end
        S_REQ: begin
          // Ready wins over timeout on the same cycle.
          if (mem_ready) begin
            if (!we) load_data <= load_val;
            state <= S_DONE;
          end else if ((TIMEOUT_CYCLES != 0) && (cnt == TO_LAST)) begin
            err   <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  lsu_align u_align (
    .op_size  (op_size),
    .sgn      (sgn),
    .off      (ea[1:0]),
    .sdata    (sdata),
    .rdata    (mem_rdata),
    .be       (st_be),
    .wdata    (st_wdata),
    .load_val (load_val)
  );

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign mem_req   = (state == S_REQ);
  assign bus_err   = done & err;
  assign misalign  = done & mis;
  assign mem_we    = mem_req & we;
  assign mem_addr  = mem_req ? {ea[31:2], 2'b00} : 32'h0;
  assign mem_be    = mem_req ? (we ? st_be : BE_WORD) : 4'h0;
  assign mem_wdata = (mem_req & we) ? st_wdata : 32'h0;

endmodule
